viterbi_chan_err_inj: RTL

Channel error-injection stage between the convolutional encoder and the Viterbi decoder. It takes one 2-bit encoded symbol per valid cycle and forwards it after a registered XOR with an error mask. The mask comes from a runtime-selected mode: off, periodic, burst or LFSR-random. It also exports an injected-error count and a symbol count so benches can score decoder correction capability.

---
 rtl/viterbi_chan_pkg.sv | 24 ++
 rtl/chan_lfsr16.sv | 33 +++
 rtl/viterbi_chan_err_inj.sv | 133 +++++++++++++
 3 files changed

// File: rtl/viterbi_chan_pkg.sv
// Shared types for the channel error-injection stage: mode and burst-state
// enums, the LFSR tap mask and a 2-bit popcount helper.
package viterbi_chan_pkg;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_BURST    = 2'd2,
    MODE_RANDOM   = 2'd3
  } chan_mode_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } burst_st_t;

  // Feedback taps at bits 15, 13, 12, 10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [1:0] popcount2(input logic [1:0] m);
    return {1'b0, m[0]} + {1'b0, m[1]};
  endfunction

endpackage

// File: rtl/chan_lfsr16.sv
// 16-bit Fibonacci LFSR that shifts once per enabled cycle.
// Ports: clk, rst (async high), en_i (advance), lfsr_o (current state).
module chan_lfsr16
  import viterbi_chan_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  output logic [15:0] lfsr_o
);

  // An all-zero state would lock up the register.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        fb;

  always_comb begin
    fb     = ^(lfsr_q & LFSR_TAPS);
    lfsr_d = en_i ? {lfsr_q[14:0], fb} : lfsr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SEED_EFF;
    else     lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/viterbi_chan_err_inj.sv
// Channel error injector: XORs each valid 2-bit symbol with an off/periodic/
// burst/random mask, registered with 1-clock latency, and keeps error and
// word counters. Ports: clk, rst, enc_i/enc_valid_i in; mode_i, period_i,
// burst_len_i, thresh_i controls; chan_o/chan_valid_o/err_inj_o and the
// error_counter_o / word_ct_o counters out.
module viterbi_chan_err_inj
  import viterbi_chan_pkg::*;
#(
  parameter int          CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       enc_i,
  input  logic             enc_valid_i,
  input  logic [1:0]       mode_i,
  input  logic [7:0]       period_i,
  input  logic [3:0]       burst_len_i,
  input  logic [7:0]       thresh_i,
  output logic [1:0]       chan_o,
  output logic             chan_valid_o,
  output logic [1:0]       err_inj_o,
  output logic [CNT_W-1:0] error_counter_o,
  output logic [CNT_W-1:0] word_ct_o
);

  chan_mode_t       mode_q;
  chan_mode_t       mode_new;
  logic             mode_chg;
  logic [7:0]       sym_ct_q, sym_ct_d, sym_eff;
  burst_st_t        st_q, st_d, st_eff;
  logic [3:0]       bct_q, bct_d;
  logic [1:0]       chan_q, chan_d;
  logic             vld_q;
  logic [1:0]       inj_q, inj_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] word_q, word_d;
  logic [CNT_W:0]   err_sum;
  logic [7:0]       per_m1;
  logic             evt;
  logic [1:0]       mask;
  logic [1:0]       rnd_mask;
  logic [15:0]      lfsr;

  // Advances on every valid symbol regardless of mode.
  chan_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .en_i   (enc_valid_i),
    .lfsr_o (lfsr)
  );

  always_comb begin
    mode_new = chan_mode_t'(mode_i);
    mode_chg = (mode_new != mode_q);
    // A mode change restarts the period and burst from scratch this cycle.
    sym_eff  = mode_chg ? 8'd0 : sym_ct_q;
    st_eff   = mode_chg ? ST_IDLE : st_q;
    per_m1   = period_i - 8'd1;
    evt      = enc_valid_i && (period_i != 8'd0) && (sym_eff == per_m1);
    rnd_mask = {(lfsr[15:8] < thresh_i), (lfsr[7:0] < thresh_i)};

    mask  = 2'b00;
    st_d  = st_eff;
    bct_d = bct_q;

    unique case (mode_new)
      MODE_OFF: mask = 2'b00;
      MODE_PERIODIC: mask = evt ? 2'b01 : 2'b00;
      MODE_BURST: begin
        if (st_eff == ST_IDLE) begin
          if (evt && (burst_len_i != 4'd0)) begin
            mask  = 2'b11;
            bct_d = burst_len_i - 4'd1;
            if (burst_len_i != 4'd1) st_d = ST_BURST;
          end
        end else if (enc_valid_i) begin
          mask  = 2'b11;
          bct_d = bct_q - 4'd1;
          if (bct_q == 4'd1) st_d = ST_IDLE;
        end
      end
      MODE_RANDOM: mask = rnd_mask;
      default: mask = 2'b00;
    endcase

    if (!enc_valid_i) mask = 2'b00;

    // Wraps 255 -> 0 so an over-shot shorter period resynchronises.
    if (enc_valid_i) sym_ct_d = evt ? 8'd0 : sym_eff + 8'd1;
    else             sym_ct_d = sym_eff;

    chan_d = enc_valid_i ? (enc_i ^ mask) : chan_q;
    inj_d  = mask;
    word_d = enc_valid_i ? word_q + 1'b1 : word_q;

    err_sum = {1'b0, err_q} + {{(CNT_W-1){1'b0}}, popcount2(mask)};
    err_d   = err_sum[CNT_W] ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= MODE_OFF;
      sym_ct_q <= 8'd0;
      st_q     <= ST_IDLE;
      bct_q    <= 4'd0;
      chan_q   <= 2'b00;
      vld_q    <= 1'b0;
      inj_q    <= 2'b00;
      err_q    <= '0;
      word_q   <= '0;
    end else begin
      mode_q   <= mode_new;
      sym_ct_q <= sym_ct_d;
      st_q     <= st_d;
      bct_q    <= bct_d;
      chan_q   <= chan_d;
      vld_q    <= enc_valid_i;
      inj_q    <= inj_d;
      err_q    <= err_d;
      word_q   <= word_d;
    end
  end

  assign chan_o          = chan_q;
  assign chan_valid_o    = vld_q;
  assign err_inj_o       = inj_q;
  assign error_counter_o = err_q;
  assign word_ct_o       = word_q;

endmodule
